// File: rtl/pool_pkg.sv
// Shared definitions for the streaming 2-D pooling engine: mode constants,
// the controller state encoding and a width helper.
package pool_pkg;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, but never below 1 so it can always size a vector.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// One accumulator per output column of the current window row:
// a single write port and a combinational read port, indexed by slot.
module pool_row_buffer
  import pool_pkg::*;
#(
  parameter int unsigned DEPTH = 14,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2-D average/max pooling: raster pixels in, pooled raster pixels
// out, one output register with a valid/ready handshake on both sides.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned POOL       = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic                                            mode,
  output logic                                            busy,
  output logic                                            done,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [RESOLUTION-1:0]                           in_pixel,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [RESOLUTION-1:0]                           out_pixel,
  output logic                                            out_last,
  output logic [clog2((IMG_W/POOL)*(IMG_H/POOL))-1:0]     out_index
);

  localparam int unsigned OUT_W    = IMG_W / POOL;
  localparam int unsigned OUT_H    = IMG_H / POOL;
  localparam int unsigned LOG_P    = $clog2(POOL);
  localparam int unsigned K        = 2 * LOG_P;
  localparam int unsigned ACC_W    = RESOLUTION + K;
  localparam int unsigned COL_W    = clog2(IMG_W);
  localparam int unsigned ROW_W    = clog2(IMG_H);
  localparam int unsigned SLOT_W   = clog2(OUT_W);
  localparam int unsigned IDX_W    = clog2(OUT_W * OUT_H);
  localparam int unsigned LAST_IDX = OUT_W * OUT_H - 1;
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (K - 1);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   in_done_q, in_done_d;
  logic                   out_valid_q, out_valid_d;
  logic [RESOLUTION-1:0]  out_pixel_q, out_pixel_d;
  logic                   out_last_q, out_last_d;
  logic [IDX_W-1:0]       out_index_q, out_index_d;

  logic                   in_fire, out_fire;
  logic                   win_first, win_last;
  logic [SLOT_W-1:0]      slot;
  logic [ACC_W-1:0]       acc_rd, acc_new, pix_ext, rounded;
  logic [RESOLUTION-1:0]  pooled;

  assign in_ready = (state_q == ST_RUN) && !in_done_q && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign slot      = SLOT_W'(col_q >> LOG_P);
  assign win_first = (row_q[LOG_P-1:0] == '0) && (col_q[LOG_P-1:0] == '0);
  assign win_last  = (row_q[LOG_P-1:0] == '1) && (col_q[LOG_P-1:0] == '1);
  assign pix_ext   = ACC_W'(in_pixel);

  pool_row_buffer #(
    .DEPTH (OUT_W),
    .WIDTH (ACC_W)
  ) u_row_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (in_fire),
    .waddr (slot),
    .wdata (acc_new),
    .raddr (slot),
    .rdata (acc_rd)
  );

  always_comb begin
    acc_new = acc_rd + pix_ext;
    if (win_first) begin
      acc_new = pix_ext;
    end else if (mode_q == MODE_MAX) begin
      acc_new = (pix_ext > acc_rd) ? pix_ext : acc_rd;
    end
  end

  // The window sum plus one half of the divisor always fits ACC_W, so the
  // half-up rounded average never wraps.
  assign rounded = acc_new + HALF;
  assign pooled  = (mode_q == MODE_MAX) ? acc_new[RESOLUTION-1:0]
                                        : RESOLUTION'(rounded >> K);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    col_d       = col_q;
    row_d       = row_q;
    in_done_d   = in_done_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          col_d       = '0;
          row_d       = '0;
          in_done_d   = 1'b0;
          out_index_d = '0;
          out_last_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (in_fire) begin
          if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(IMG_H - 1)) begin
              row_d     = '0;
              in_done_d = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        if (out_fire) begin
          out_valid_d = 1'b0;
          if (!out_last_q) out_index_d = out_index_q + IDX_W'(1);
        end
        // A completing window may load in the same cycle the old output retires.
        if (in_fire && win_last) begin
          out_valid_d = 1'b1;
          out_pixel_d = pooled;
          out_last_d  = (out_index_d == IDX_W'(LAST_IDX));
        end
        if (out_fire && out_last_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_AVG;
      col_q       <= '0;
      row_q       <= '0;
      in_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_done_q   <= in_done_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;

endmodule
